// File: rtl/wbm_host_seq_if.sv
// wbm_host_seq_if: 32-bit Wishbone classic bus between the host sequencer (master) and the slave controller
// Signals: wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o driven by the master; wbm_dat_i/ack_i driven by the slave.
interface wbm_host_seq_if #(parameter int ADDR_W = 32);
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [31:0]       wbm_dat_o;
  logic [31:0]       wbm_dat_i;
  logic              wbm_ack_i;
  modport master(output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, input wbm_dat_i, wbm_ack_i);
  modport slave(input wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, output wbm_dat_i, wbm_ack_i);
endinterface

// File: rtl/wbm_host_seq.sv
// wbm_host_seq: sequences host commands into Wishbone classic beats, splitting 64-bit accesses into lo/hi 32-bit beats
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_we/cmd_wide/cmd_adr/cmd_wdata command in;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err response out; wb (master modport) Wishbone bus.
// Build option: define WBM_TIMEOUT_EN to abort a beat after TIMEOUT_CYCLES cycles without ack (rsp_err=1).
module wbm_host_seq #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic                cmd_wide,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [63:0]         cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [63:0]         rsp_rdata,
  output logic                rsp_err,
  wbm_host_seq_if.master      wb
);
  typedef enum logic [2:0] {IDLE, BEAT_LO, GAP, BEAT_HI, RESP} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, wide_q, wide_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [3:0] sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d, hi_q, hi_d;
  logic [63:0] rdata_q, rdata_d;
  logic in_beat, expired;
  assign in_beat = (state_q == BEAT_LO) || (state_q == BEAT_HI);
`ifdef WBM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // counter holds the number of ack-less cycles already spent in this beat
  assign expired = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign tmo_d   = in_beat ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    hi_d        = hi_q;
    wide_d      = wide_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = BEAT_LO;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = cmd_we;
        sel_d   = 4'hF;
        adr_d   = cmd_adr & ~ADDR_W'(cmd_wide ? 7 : 3);
        dat_d   = cmd_wdata[31:0];
        hi_d    = cmd_wdata[63:32];
        wide_d  = cmd_wide;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      BEAT_LO, BEAT_HI: if (wb.wbm_ack_i || expired) begin
        stb_d = 1'b0;
        if (!wb.wbm_ack_i) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (state_q == BEAT_LO) rdata_d[31:0] = we_q ? 32'h0 : wb.wbm_dat_i;
        else rdata_d[63:32] = we_q ? 32'h0 : wb.wbm_dat_i;
        if (wb.wbm_ack_i && state_q == BEAT_LO && wide_q) state_d = GAP;
        else begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'h0;
          rsp_valid_d = 1'b1;
        end
      end
      GAP: begin
        state_d = BEAT_HI;
        stb_d   = 1'b1;
        adr_d   = adr_q | ADDR_W'(4);
        dat_d   = hi_q;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= '0;
      dat_q       <= '0;
      hi_q        <= '0;
      wide_q      <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      hi_q        <= hi_d;
      wide_q      <= wide_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  // qualified by rst_n so the host never sees ready while reset is held
  assign cmd_ready    = rst_n && (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign wb.wbm_cyc_o = cyc_q;
  assign wb.wbm_stb_o = stb_q;
  assign wb.wbm_we_o  = we_q;
  assign wb.wbm_sel_o = sel_q;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;
endmodule

// File: tb/tb_wbm_host_seq.sv
// tb_wbm_host_seq: directed table-driven bench for wbm_host_seq with a Wishbone slave model
module tb_wbm_host_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_we = 1'b0, cmd_wide = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [63:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  wbm_host_seq_if #(.ADDR_W(32)) wb();
  wbm_host_seq #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_wide(cmd_wide), .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .wb(wb));

  typedef struct {
    logic we; logic wide; logic [31:0] adr; logic [63:0] wdata; logic [31:0] d_lo; logic [31:0] d_hi;
    int waits; int bp; int nbeats; logic [31:0] a0; logic [31:0] a1; logic [31:0] w0; logic [31:0] w1;
    int lat; int gaps; logic [63:0] rdata; logic err;
  } vec_t;
  vec_t v[6];

  int total = 0, passed = 0;
  int waits = 0, waits_hi = 0, nb = 0, gaps = 0, cnt = 0;
  logic [31:0] bdata[2], la[2], ld[2];
  logic lw[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // slave model: acks after a programmable number of wait cycles, logs each beat
  initial begin
    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb.wbm_ack_i) begin
        chk("stb_low_after_ack", 64'(wb.wbm_stb_o), 64'd0);
        wb.wbm_ack_i = 1'b0;
        cnt = 0;
      end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
        if (cnt >= (nb == 0 ? waits : waits_hi)) begin
          wb.wbm_ack_i = 1'b1;
          wb.wbm_dat_i = bdata[nb < 2 ? nb : 1];
          if (nb < 2) begin
            la[nb] = wb.wbm_adr_o;
            ld[nb] = wb.wbm_dat_o;
            lw[nb] = wb.wbm_we_o;
          end
          nb++;
        end else cnt++;
      end else cnt = 0;
      if (wb.wbm_cyc_o && !wb.wbm_stb_o) gaps++;
    end
  end

  task automatic run(input vec_t t, input string tag);
    int lat;
    logic busy, bad;
    logic [63:0] held;
    nb = 0; gaps = 0; waits = t.waits; waits_hi = t.waits;
    bdata[0] = t.d_lo; bdata[1] = t.d_hi;
    la[0] = '0; la[1] = '0; ld[0] = '0; ld[1] = '0; lw[0] = 1'b0; lw[1] = 1'b0;
    @(negedge clk);
    chk({tag, ".cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_we = t.we; cmd_wide = t.wide; cmd_adr = t.adr; cmd_wdata = t.wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; busy = 1'b0;
    while (!rsp_valid && lat < 200) begin
      if (cmd_ready) busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(t.lat));
    chk({tag, ".rsp_rdata"}, rsp_rdata, t.rdata);
    chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(t.err));
    chk({tag, ".beats"}, 64'(nb), 64'(t.nbeats));
    chk({tag, ".gap_cycles"}, 64'(gaps), 64'(t.gaps));
    chk({tag, ".cmd_ready_busy"}, 64'(busy), 64'd0);
    if (t.nbeats > 0) begin
      chk({tag, ".lo_adr"}, 64'(la[0]), 64'(t.a0));
      chk({tag, ".lo_dat"}, 64'(ld[0]), 64'(t.w0));
      chk({tag, ".lo_we"}, 64'(lw[0]), 64'(t.we));
    end
    if (t.nbeats > 1) begin
      chk({tag, ".hi_adr"}, 64'(la[1]), 64'(t.a1));
      chk({tag, ".hi_dat"}, 64'(ld[1]), 64'(t.w1));
      chk({tag, ".hi_we"}, 64'(lw[1]), 64'(t.we));
    end
    held = rsp_rdata; bad = 1'b0;
    for (int i = 0; i < t.bp; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held || cmd_ready || wb.wbm_cyc_o || wb.wbm_stb_o) bad = 1'b1;
    end
    chk({tag, ".backpressure_stable"}, 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_consumed"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".cmd_ready_after"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int k;
    logic seen;
    vec_t tmo;
    v[0] = '{1'b1, 1'b0, 32'h3000_0004, 64'h1, 32'h5555_5555, 32'h0, 1, 0, 1, 32'h3000_0004, 32'h0, 32'h1, 32'h0, 3, 0, 64'h0, 1'b0};
    v[1] = '{1'b0, 1'b1, 32'h3001_0008, 64'h0, 32'hDEAD_BEEF, 32'h0000_1010, 0, 0, 2, 32'h3001_0008, 32'h3001_000C, 32'h0, 32'h0, 4, 1, 64'h0000_1010_DEAD_BEEF, 1'b0};
    v[2] = '{1'b1, 1'b1, 32'h3002_0018, 64'hFEDC_BA98_7654_3210, 32'h1111_1111, 32'h2222_2222, 2, 0, 2, 32'h3002_0018, 32'h3002_001C, 32'h7654_3210, 32'hFEDC_BA98, 8, 1, 64'h0, 1'b0};
    v[3] = '{1'b0, 1'b0, 32'h4000_0007, 64'h0, 32'hCAFE_F00D, 32'h0, 0, 5, 1, 32'h4000_0004, 32'h0, 32'h0, 32'h0, 2, 0, 64'h0000_0000_CAFE_F00D, 1'b0};
    v[4] = '{1'b0, 1'b1, 32'h5000_000C, 64'h0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 2, 2, 32'h5000_0008, 32'h5000_000C, 32'h0, 32'h0, 6, 1, 64'h9ABC_DEF0_1234_5678, 1'b0};
    v[5] = '{1'b1, 1'b0, 32'h0000_0002, 64'hAAAA_BBBB_CCCC_DDDD, 32'h0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'hCCCC_DDDD, 32'h0, 2, 0, 64'h0, 1'b0};
    #12;
    chk("rst.cmd_ready_low", 64'(cmd_ready), 64'd0);
    chk("rst.cyc", 64'(wb.wbm_cyc_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rsp_err", 64'(rsp_err), 64'd0);
    chk("rst.rsp_rdata", rsp_rdata, 64'd0);
    chk("rst.bus_ctl", {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o}, 64'd0);
    chk("rst.adr", 64'(wb.wbm_adr_o), 64'd0);
    chk("rst.dat_o", 64'(wb.wbm_dat_o), 64'd0);
    for (int i = 0; i < 6; i++) run(v[i], $sformatf("vec%0d", i));
    // reset asserted while the hi beat of a wide read is stalled
    nb = 0; gaps = 0; waits = 0; waits_hi = 1000;
    bdata[0] = 32'h0BAD_0BAD; bdata[1] = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_wide = 1'b1; cmd_adr = 32'h3001_0008;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!(wb.wbm_stb_o && wb.wbm_adr_o == 32'h3001_000C) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid.reached_hi", 64'(wb.wbm_stb_o && wb.wbm_adr_o == 32'h3001_000C), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.cyc_async", 64'(wb.wbm_cyc_o), 64'd0);
    chk("rstmid.stb_async", 64'(wb.wbm_stb_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || wb.wbm_cyc_o) seen = 1'b1;
    end
    chk("rstmid.no_response", 64'(seen), 64'd0);
    chk("rstmid.cmd_ready", 64'(cmd_ready), 64'd1);
    run(v[3], "post_reset_read");
`ifdef WBM_TIMEOUT_EN
    tmo = '{1'b0, 1'b1, 32'h3001_0008, 64'h0, 32'h0, 32'h0, 1000, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 17, 0, 64'h0, 1'b1};
    run(tmo, "timeout");
`else
    tmo = v[0];
    run(tmo, "repeat_write");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wbm_host_seq.md
# wbm_host_seq

Wishbone classic-cycle initiator that sequences host commands into bus transactions toward the accelerator's Wishbone slave controller. It sits between a command source (test harness or host-side sequencer loading query patches, leaves and internal nodes) and the 32-bit Wishbone slave port. It splits 64-bit accesses into lower/upper 32-bit beats at byte offsets +0/+4 and reassembles 64-bit read data. It returns one response per command.

## Interface
- ADDR_W, 32, Wishbone byte-address width
- TIMEOUT_CYCLES, 16, max cycles a beat may wait for ack (used only with WBM_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_wide  in  1  1 = 64-bit (two beats), 0 = 32-bit (one beat)
- cmd_adr  in  ADDR_W  byte address
- cmd_wdata  in  64  write data; narrow uses [31:0]
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  64  read data; narrow read zero-extended; 0 for writes
- rsp_err  out  1  beat timed out
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe, write enable
- wbm_sel_o  out  4  byte select, always 4'hF during a beat
- wbm_adr_o  out  ADDR_W  beat address
- wbm_dat_o  out  32  beat write data
- wbm_dat_i  in  32  slave read data, sampled with ack
- wbm_ack_i  in  1  slave acknowledge

## Operation
- States: IDLE, BEAT_LO, GAP, BEAT_HI, RESP.
- IDLE: cmd_ready=1; on accept, latch cmd fields → BEAT_LO. All other states cmd_ready=0.
- Addressing: wide: BEAT_LO adr = {cmd_adr[ADDR_W-1:3],3'b000}, BEAT_HI adr = {cmd_adr[ADDR_W-1:3],3'b100}. Narrow: adr = {cmd_adr[ADDR_W-1:2],2'b00}.
- BEAT_LO/BEAT_HI: cyc=stb=1, we=latched cmd_we, sel=4'hF, dat_o = wdata[31:0] / wdata[63:32].
- Ack sampled high in a beat: capture wbm_dat_i into rdata[31:0] (lo) or rdata[63:32] (hi). From BEAT_LO: wide → GAP, narrow → RESP. From BEAT_HI → RESP.
- GAP: one cycle, cyc=1, stb=0 (slave must see strobe drop before next beat) → BEAT_HI.
- RESP: cyc=stb=0, rsp_valid=1, outputs stable until rsp_ready → IDLE.
- Write responses: rsp_rdata=0. wbm_ack_i outside BEAT states ignored.

## Timing
- Reset values: cmd_ready=1 after reset release (0 while rst_n low); rsp_valid=0, rsp_err=0, rsp_rdata=0, cyc/stb/we=0, sel=0, adr=0, dat_o=0.
- Command accepted at edge T → cyc/stb high from cycle T+1.
- Ack at edge A → stb low from A+1 (no beat ever sees stb high after its ack edge).
- Zero-wait slave (ack at first edge of beat): narrow = 2 cycles accept-to-rsp_valid; wide = 4 cycles.
- rsp_valid held with rsp_ready=0 indefinitely; next command accepted no earlier than the cycle after the rsp handshake.
- Reset asserted mid-transaction: cyc/stb drop asynchronously, command and any partial data discarded, no response issued.

## Configuration
- WBM_TIMEOUT_EN defined: per-beat counter starts at 0 on beat entry, increments each cycle without ack; at TIMEOUT_CYCLES without ack, beat aborts: cyc/stb drop next cycle, remaining beat skipped, → RESP with rsp_err=1, rsp_rdata=0. Ack on the same edge as the limit wins (no error).
- Not defined: no counter; beat waits for ack forever; rsp_err tied 0.

## Test plan
- Narrow write adr 0x3000_0004, data 1, ack after 1 wait → one beat adr 0x3000_0004, dat_o 0x1, we=1; rsp_valid, rsp_err=0, rsp_rdata=0.
- Wide read adr 0x3001_0008, slave returns 0xDEAD_BEEF then 0x0000_1010 → beats at 0x3001_0008 and 0x3001_000C, stb low one GAP cycle between, rsp_rdata=0x0000_1010_DEAD_BEEF.
- Wide write adr 0x3002_0018, wdata 0xFEDC_BA98_7654_3210 → lo beat dat 0x7654_3210, hi beat 0xFEDC_BA98 at 0x3002_001C; cmd_ready=0 throughout.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stable, cmd_ready=0, no bus activity; accept resumes after handshake.
- WBM_TIMEOUT_EN, TIMEOUT_CYCLES=16, wide read, slave never acks → after 16 cycles stb/cyc drop, no hi beat, rsp_err=1, rsp_rdata=0.
- rst_n low during BEAT_HI of wide read → cyc/stb immediately 0, rsp_valid stays 0; after release cmd_ready=1 and new narrow read completes normally.
